// File: rtl/cla32_bist.sv
`default_nettype none
// ============================================================================
// Module   : cla32_bist
// Brief    : At-speed self-test engine for a combinational WIDTH-bit adder.
//            It drives LFSR vectors and compares {cout,sum} with a golden sum.
//            Optional macro CLA_BIST_CORNER_EN adds four fixed corner vectors
//            ahead of the random ones.
// Revision : 1.0 - initial release
// ============================================================================
module cla32_bist #(
    parameter int          WIDTH       = 32,
    parameter int          NUM_VECTORS = 200,
    parameter logic [31:0] SEED_A      = 32'h1ACE_B00C,
    parameter logic [31:0] SEED_B      = 32'h0BAD_F00D
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [WIDTH-1:0] dut_a,
    output logic [WIDTH-1:0] dut_b,
    output logic             dut_cin,
    input  logic [WIDTH-1:0] dut_sum,
    input  logic             dut_cout,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [15:0]      err_count,
    output logic             first_err_valid,
    output logic [WIDTH-1:0] first_err_a,
    output logic [WIDTH-1:0] first_err_b,
    output logic             first_err_cin
);

    localparam logic [1:0]  S_IDLE  = 2'd0;
    localparam logic [1:0]  S_DRIVE = 2'd1;
    localparam logic [1:0]  S_CHECK = 2'd2;
    localparam logic [1:0]  S_DONE  = 2'd3;

    // Right-shifting Galois taps for x^32+x^22+x^2+x+1
    localparam logic [31:0] c_poly   = 32'h8020_0003;
    localparam logic [31:0] c_seed_a = (SEED_A == 32'd0) ? 32'd1 : SEED_A;
    localparam logic [31:0] c_seed_b = (SEED_B == 32'd0) ? 32'd1 : SEED_B;
    localparam logic [15:0] c_last   = 16'(NUM_VECTORS - 1);

    logic [1:0]       r_state, w_state_nxt;
    logic [31:0]      r_lfsr_a, r_lfsr_b, w_lfsr_a_nxt, w_lfsr_b_nxt;
    logic [15:0]      r_vec_cnt, r_err_count;
    logic [WIDTH-1:0] r_dut_a, r_dut_b, r_ferr_a, r_ferr_b;
    logic             r_dut_cin, r_ferr_cin, r_ferr_valid;
    logic             r_busy, r_done, w_busy, w_done;
    logic [WIDTH-1:0] w_drv_a, w_drv_b;
    logic             w_drv_cin, w_in_corner, w_mismatch;
    logic [WIDTH:0]   w_golden;

`ifdef CLA_BIST_CORNER_EN
    logic [2:0] r_corner_idx;
    assign w_in_corner = ~r_corner_idx[2];
`else
    assign w_in_corner = 1'b0;
`endif

    assign w_lfsr_a_nxt = {1'b0, r_lfsr_a[31:1]} ^ (r_lfsr_a[0] ? c_poly : 32'd0);
    assign w_lfsr_b_nxt = {1'b0, r_lfsr_b[31:1]} ^ (r_lfsr_b[0] ? c_poly : 32'd0);

    always_comb begin
        w_drv_a   = WIDTH'(r_lfsr_a);
        w_drv_b   = WIDTH'(r_lfsr_b);
        w_drv_cin = r_lfsr_a[0] ^ r_lfsr_b[0];
`ifdef CLA_BIST_CORNER_EN
        if (w_in_corner) begin
            case (r_corner_idx[1:0])
                2'd0:    begin w_drv_a = '0;              w_drv_b = '0;              w_drv_cin = 1'b0; end
                2'd1:    begin w_drv_a = '1;              w_drv_b = '0;              w_drv_cin = 1'b1; end
                2'd2:    begin w_drv_a = '1;              w_drv_b = '1;              w_drv_cin = 1'b1; end
                default: begin w_drv_a = WIDTH'(32'hAAAA_AAAA); w_drv_b = WIDTH'(32'h5555_5555); w_drv_cin = 1'b1; end
            endcase
        end
`endif
    end

    assign w_golden   = {1'b0, r_dut_a} + {1'b0, r_dut_b} + {{WIDTH{1'b0}}, r_dut_cin};
    assign w_mismatch = ({dut_cout, dut_sum} != w_golden);

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_DRIVE;
            S_DRIVE: w_state_nxt = S_CHECK;
            S_CHECK: w_state_nxt = (!w_in_corner && r_vec_cnt == c_last) ? S_DONE : S_DRIVE;
            S_DONE:  if (start) w_state_nxt = S_DRIVE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        w_busy = (r_state == S_DRIVE) || (r_state == S_CHECK);
        w_done = (r_state == S_DONE);
    end

    // Status flags trail the state by one cycle, so done rises on edge k+1+2*N.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_lfsr_a     <= c_seed_a;
            r_lfsr_b     <= c_seed_b;
            r_vec_cnt    <= '0;
            r_err_count  <= '0;
            r_dut_a      <= '0;
            r_dut_b      <= '0;
            r_dut_cin    <= 1'b0;
            r_ferr_valid <= 1'b0;
            r_ferr_a     <= '0;
            r_ferr_b     <= '0;
            r_ferr_cin   <= 1'b0;
`ifdef CLA_BIST_CORNER_EN
            r_corner_idx <= '0;
`endif
        end else begin
            r_busy <= w_busy;
            r_done <= w_done;
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_lfsr_a     <= c_seed_a;
                        r_lfsr_b     <= c_seed_b;
                        r_vec_cnt    <= '0;
                        r_err_count  <= '0;
                        r_ferr_valid <= 1'b0;
                        r_ferr_a     <= '0;
                        r_ferr_b     <= '0;
                        r_ferr_cin   <= 1'b0;
`ifdef CLA_BIST_CORNER_EN
                        r_corner_idx <= '0;
`endif
                    end
                end
                S_DRIVE: begin
                    r_dut_a   <= w_drv_a;
                    r_dut_b   <= w_drv_b;
                    r_dut_cin <= w_drv_cin;
                    if (!w_in_corner) begin
                        r_lfsr_a <= w_lfsr_a_nxt;
                        r_lfsr_b <= w_lfsr_b_nxt;
                    end
                end
                default: begin
                    if (w_mismatch) begin
                        if (r_err_count != 16'hFFFF) r_err_count <= r_err_count + 16'd1;
                        if (!r_ferr_valid) begin
                            r_ferr_valid <= 1'b1;
                            r_ferr_a     <= r_dut_a;
                            r_ferr_b     <= r_dut_b;
                            r_ferr_cin   <= r_dut_cin;
                        end
                    end
`ifdef CLA_BIST_CORNER_EN
                    if (w_in_corner) r_corner_idx <= r_corner_idx + 3'd1;
                    else             r_vec_cnt    <= r_vec_cnt + 16'd1;
`else
                    r_vec_cnt <= r_vec_cnt + 16'd1;
`endif
                end
            endcase
        end
    end

    assign dut_a           = r_dut_a;
    assign dut_b           = r_dut_b;
    assign dut_cin         = r_dut_cin;
    assign busy            = r_busy;
    assign done            = r_done;
    assign pass            = r_done && (r_err_count == 16'd0);
    assign err_count       = r_err_count;
    assign first_err_valid = r_ferr_valid;
    assign first_err_a     = r_ferr_a;
    assign first_err_b     = r_ferr_b;
    assign first_err_cin   = r_ferr_cin;

endmodule
`default_nettype wire

// File: doc/cla32_bist.md
Name: cla32_bist

Overview:
- Self-checking stimulus engine for the 32-bit carry-lookahead adder; the hardware counterpart of the bench's drive/check loop.
- Generates pseudo-random {a, b, cin} vectors and drives them into a combinational adder DUT.
- Compares the returned {cout, sum} against a behavioural golden sum and counts mismatches.
- Captures the first failing vector; sits beside the adder on silicon or FPGA for at-speed self-test.

Parameters:
- WIDTH, 32, operand width of the DUT.
- NUM_VECTORS, 200, number of random vectors per run; legal range 1..65535.
- SEED_A, 32'h1ACE_B00C, initial state of the a-operand LFSR; value 0 is replaced by 1.
- SEED_B, 32'h0BAD_F00D, initial state of the b-operand LFSR; value 0 is replaced by 1.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begin a run; sampled only in IDLE or DONE.
- dut_a  out  WIDTH  operand a to DUT (registered).
- dut_b  out  WIDTH  operand b to DUT (registered).
- dut_cin  out  1  carry-in to DUT (registered).
- dut_sum  in  WIDTH  DUT sum.
- dut_cout  in  1  DUT carry-out.
- busy  out  1  high in DRIVE/CHECK.
- done  out  1  high while in DONE.
- pass  out  1  valid when done; 1 iff err_count == 0.
- err_count  out  16  mismatch count, saturating at 16'hFFFF.
- first_err_valid  out  1  a mismatch has been captured this run.
- first_err_a  out  WIDTH  a of first failing vector.
- first_err_b  out  WIDTH  b of first failing vector.
- first_err_cin  out  1  cin of first failing vector.

Behaviour:
- Reset:
  - FSM to IDLE; all outputs 0; LFSRs reload SEED_A/SEED_B; vector counter 0.
  - A reset mid-run aborts immediately with the same values; no partial results are retained.
- FSM states: IDLE, DRIVE, CHECK, DONE.
  - IDLE: start=1 -> DRIVE. Clear err_count, first_err_*, vector counter. Reload LFSRs.
  - DRIVE (1 cycle): register dut_a=lfsr_a, dut_b=lfsr_b, dut_cin=lfsr_a[0]^lfsr_b[0]. Advance both LFSRs. Go to CHECK.
  - CHECK (1 cycle): sample {dut_cout, dut_sum} and compare to golden = dut_a + dut_b + dut_cin, computed (WIDTH+1) bits wide from the registered drive values.
    - On mismatch: err_count+1, saturating.
    - On the first mismatch: capture first_err_* and set first_err_valid.
    - Counter+1. If counter == NUM_VECTORS-1 -> DONE, else -> DRIVE.
  - DONE: done=1, busy=0, results held. start=1 -> same as from IDLE (clear, reload, DRIVE). A run is therefore repeatable and deterministic.
- start is ignored while busy.
- LFSRs: 32-bit Galois, polynomial x^32+x^22+x^2+x+1, shifting right with feedback from bit 0.
- Timing:
  - Each vector takes 2 cycles; the DUT has one full cycle of settle time.
  - If start is sampled at edge k, the first vector is on dut_* after edge k+1, and done rises after edge k+1+2*NUM_VECTORS.
- Simultaneous events: rst wins over start. A mismatch on the final CHECK is counted before entering DONE.
- pass is meaningful only when done=1; it reads 0 otherwise.

Optional Feature:
- Macro: CLA_BIST_CORNER_EN.
- Defined: four fixed corner vectors are driven before the random ones, each as a DRIVE/CHECK pair:
  - (0, 0, 0)
  - (FFFFFFFF, 0, 1)
  - (FFFFFFFF, FFFFFFFF, 1)
  - (AAAAAAAA, 55555555, 1)
  - LFSRs do not advance during corner vectors. The run totals NUM_VECTORS+4 vectors and done timing shifts by +8 cycles.
- Undefined: random vectors only; no corner logic is synthesised.

Test Plan:
- Correct DUT (behavioural a+b+cin), NUM_VECTORS=200, start pulse at edge k -> done=1 after edge k+401, pass=1, err_count=0, first_err_valid=0, busy high for exactly 400 cycles.
- Faulty DUT with sum bit 0 inverted -> err_count=200, pass=0, first_err_a/b/cin equal the first driven vector (SEED_A, SEED_B, SEED_A[0]^SEED_B[0]).
- Faulty DUT with cout stuck at 0 -> err_count equals the number of vectors whose golden bit 32 is 1, which the bench counts independently. first_err_* match that first carry-out vector.
- Rerun: start again in DONE -> identical dut_a/dut_b sequence and identical err_count. start pulsed while busy -> no effect on counter or timing.
- rst asserted during vector 50 -> next cycle: IDLE, all outputs 0. A subsequent start reproduces the vector-0 values.
- With CLA_BIST_CORNER_EN and a correct DUT -> first four driven vectors exactly the corner list. Vector 5 = (SEED_A, SEED_B). done after edge k+409, pass=1.
